// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB arbiter with round-robin grant, a single transfer in flight,
// and a DATA-phase timeout that aborts stalled transfers with an ERROR response.
module ahb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              m_req,
  input  logic [2*ADDR_WIDTH-1:0] m_haddr,
  input  logic [2*DATA_WIDTH-1:0] m_hwdata,
  input  logic [1:0]              m_hwrite,
  input  logic [5:0]              m_hsize,
  input  logic [5:0]              m_hburst,
  output logic [1:0]              m_gnt,
  output logic [DATA_WIDTH-1:0]   m_hrdata,
  output logic [1:0]              m_hready,
  output logic [1:0]              m_hresp,
  output logic                    s_hsel,
  output logic [ADDR_WIDTH-1:0]   s_haddr,
  output logic [DATA_WIDTH-1:0]   s_hwdata,
  output logic                    s_hwrite,
  output logic [2:0]              s_hsize,
  output logic [2:0]              s_hburst,
  input  logic [DATA_WIDTH-1:0]   s_hrdata,
  input  logic                    s_hready,
  input  logic [1:0]              s_hresp,
  output logic [7:0]              timeout_cnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_reg;
  logic [1:0]              gnt_reg;
  logic                    gnt_idx_reg;
  logic                    last_served_reg;
  logic [7:0]              wait_cnt_reg;
  logic [7:0]              timeout_cnt_reg;
  logic                    s_hsel_reg;
  logic [ADDR_WIDTH-1:0]   s_haddr_reg;
  logic                    s_hwrite_reg;
  logic [2:0]              s_hsize_reg;
  logic [2:0]              s_hburst_reg;

  logic [ADDR_WIDTH-1:0]   haddr_arr  [2];
  logic [DATA_WIDTH-1:0]   hwdata_arr [2];
  logic [2:0]              hsize_arr  [2];
  logic [2:0]              hburst_arr [2];

  logic winner;
  logic data_phase;
  logic ok_done;
  logic timeout_hit;
  logic xfer_done;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign haddr_arr[gi]  = m_haddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign hwdata_arr[gi] = m_hwdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign hsize_arr[gi]  = m_hsize[gi*3 +: 3];
    assign hburst_arr[gi] = m_hburst[gi*3 +: 3];
    // Grant is one-hot and held through DATA, so it selects the strobe target.
    assign m_hready[gi]   = xfer_done & gnt_reg[gi];
  end

  // On a tie the master that was not served last wins.
  assign winner      = (m_req == 2'b11) ? ~last_served_reg : m_req[1];

  assign data_phase  = (state_reg == DATA);
  assign ok_done     = data_phase && s_hready;
  assign timeout_hit = data_phase && !s_hready && (wait_cnt_reg == WAIT_LAST);
  assign xfer_done   = ok_done || timeout_hit;

  // RETRY and SPLIT are not supported by the masters, so they become ERROR.
  always_comb begin
    m_hresp  = 2'b00;
    m_hrdata = '0;
    if (ok_done) begin
      m_hresp  = s_hresp[1] ? 2'b01 : s_hresp;
      m_hrdata = s_hrdata;
    end else if (timeout_hit) begin
      m_hresp  = 2'b01;
    end
  end

  assign s_hwdata    = data_phase ? hwdata_arr[gnt_idx_reg] : '0;
  assign m_gnt       = gnt_reg;
  assign s_hsel      = s_hsel_reg;
  assign s_haddr     = s_haddr_reg;
  assign s_hwrite    = s_hwrite_reg;
  assign s_hsize     = s_hsize_reg;
  assign s_hburst    = s_hburst_reg;
  assign timeout_cnt = timeout_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      gnt_reg         <= 2'b00;
      gnt_idx_reg     <= 1'b0;
      last_served_reg <= 1'b1;
      wait_cnt_reg    <= 8'd0;
      timeout_cnt_reg <= 8'd0;
      s_hsel_reg      <= 1'b0;
      s_haddr_reg     <= '0;
      s_hwrite_reg    <= 1'b0;
      s_hsize_reg     <= 3'd0;
      s_hburst_reg    <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|m_req) begin
            state_reg    <= ADDR;
            gnt_idx_reg  <= winner;
            gnt_reg      <= winner ? 2'b10 : 2'b01;
            s_hsel_reg   <= 1'b1;
            s_haddr_reg  <= haddr_arr[winner];
            s_hwrite_reg <= m_hwrite[winner];
            s_hsize_reg  <= hsize_arr[winner];
            s_hburst_reg <= hburst_arr[winner];
          end
        end
        ADDR: begin
          state_reg    <= DATA;
          s_hsel_reg   <= 1'b0;
          wait_cnt_reg <= 8'd0;
        end
        DATA: begin
          if (xfer_done) begin
            state_reg       <= IDLE;
            gnt_reg         <= 2'b00;
            last_served_reg <= gnt_idx_reg;
            wait_cnt_reg    <= 8'd0;
            s_haddr_reg     <= '0;
            s_hwrite_reg    <= 1'b0;
            s_hsize_reg     <= 3'd0;
            s_hburst_reg    <= 3'd0;
            if (timeout_hit && timeout_cnt_reg != 8'hFF) begin
              timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Directed bench for ahb_arbiter_2m: single transfer, round-robin, wait states,
// timeout with saturation, reset mid-transfer and response mapping.
module tb_ahb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [63:0] m_haddr;
  logic [63:0] m_hwdata;
  logic [1:0]  m_hwrite;
  logic [5:0]  m_hsize;
  logic [5:0]  m_hburst;
  logic [1:0]  m_gnt;
  logic [31:0] m_hrdata;
  logic [1:0]  m_hready;
  logic [1:0]  m_hresp;
  logic        s_hsel;
  logic [31:0] s_haddr;
  logic [31:0] s_hwdata;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic [1:0]  s_hresp;
  logic [7:0]  timeout_cnt;

  int total;
  int bad;

  localparam logic [31:0] ADDR0  = 32'h1000_0010;
  localparam logic [31:0] ADDR1  = 32'h2000_0040;
  localparam logic [31:0] WDATA0 = 32'hAAAA_0000;
  localparam logic [31:0] WDATA1 = 32'hBBBB_0001;

  ahb_arbiter_2m dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req),
    .m_haddr     (m_haddr),
    .m_hwdata    (m_hwdata),
    .m_hwrite    (m_hwrite),
    .m_hsize     (m_hsize),
    .m_hburst    (m_hburst),
    .m_gnt       (m_gnt),
    .m_hrdata    (m_hrdata),
    .m_hready    (m_hready),
    .m_hresp     (m_hresp),
    .s_hsel      (s_hsel),
    .s_haddr     (s_haddr),
    .s_hwdata    (s_hwdata),
    .s_hwrite    (s_hwrite),
    .s_hsize     (s_hsize),
    .s_hburst    (s_hburst),
    .s_hrdata    (s_hrdata),
    .s_hready    (s_hready),
    .s_hresp     (s_hresp),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m_req    = 2'b00;
    s_hready = 1'b0;
    s_hresp  = 2'b00;
    s_hrdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    #2;
    if (m_hready != 2'b00)
      $display("xfer hready=%b hresp=%b hrdata=%h timeouts=%0d", m_hready, m_hresp, m_hrdata, timeout_cnt);
  end

  initial begin
    logic [1:0] exp_gnt;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    m_req    = 2'b00;
    s_hready = 1'b0;
    s_hresp  = 2'b00;
    s_hrdata = 32'h0;
    m_haddr  = {ADDR1, ADDR0};
    m_hwdata = {WDATA1, WDATA0};
    m_hwrite = 2'b10;
    m_hsize  = {3'd1, 3'd2};
    m_hburst = {3'b011, 3'b000};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_gnt",      64'(m_gnt),       64'h0);
    check_val("rst_hready",   64'(m_hready),    64'h0);
    check_val("rst_hsel",     64'(s_hsel),      64'h0);
    check_val("rst_timeouts", 64'(timeout_cnt), 64'h0);
    rst_n = 1'b1;

    // Single master-0 transfer with zero wait states
    step();
    m_req = 2'b01; s_hready = 1'b1; s_hrdata = 32'hDEAD_BEEF;
    #1 check_val("t1_c0_gnt", 64'(m_gnt), 64'h0);
    step();
    #1;
    check_val("t1_c1_gnt",    64'(m_gnt),    64'h1);
    check_val("t1_c1_hsel",   64'(s_hsel),   64'h1);
    check_val("t1_c1_haddr",  64'(s_haddr),  64'(ADDR0));
    check_val("t1_c1_hready", 64'(m_hready), 64'h0);
    m_req = 2'b00;
    step();
    #1;
    check_val("t1_c2_hready", 64'(m_hready), 64'h1);
    check_val("t1_c2_hrdata", 64'(m_hrdata), 64'hDEAD_BEEF);
    check_val("t1_c2_hresp",  64'(m_hresp),  64'h0);
    check_val("t1_c2_hsel",   64'(s_hsel),   64'h0);
    check_val("t1_c2_hwdata", 64'(s_hwdata), 64'(WDATA0));
    step();
    #1;
    check_val("t1_c3_gnt",    64'(m_gnt),    64'h0);
    check_val("t1_c3_hready", 64'(m_hready), 64'h0);
    check_val("t1_c3_hrdata", 64'(m_hrdata), 64'h0);

    // Both masters requesting continuously: alternating grants
    do_reset();
    step();
    m_req = 2'b11; s_hready = 1'b1; s_hrdata = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1 check_val("rr_idle_gnt", 64'(m_gnt), 64'h0);
      step();
      #1;
      check_val("rr_addr_gnt",   64'(m_gnt),   64'(exp_gnt));
      check_val("rr_addr_haddr", 64'(s_haddr), (k % 2 == 0) ? 64'(ADDR0) : 64'(ADDR1));
      step();
      #1 check_val("rr_data_hready", 64'(m_hready), 64'(exp_gnt));
      step();
    end
    m_req = 2'b00;

    // Master 1 with three wait states, control passthrough, SPLIT mapped to ERROR
    do_reset();
    step();
    m_req = 2'b10; s_hready = 1'b0; s_hresp = 2'b10; s_hrdata = 32'h1234_5678;
    step();
    #1;
    check_val("t3_addr_gnt",    64'(m_gnt),    64'h2);
    check_val("t3_addr_haddr",  64'(s_haddr),  64'(ADDR1));
    check_val("t3_addr_hwrite", 64'(s_hwrite), 64'h1);
    check_val("t3_addr_hsize",  64'(s_hsize),  64'h1);
    check_val("t3_addr_hburst", 64'(s_hburst), 64'h3);
    m_req = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t3_wait_hready", 64'(m_hready), 64'h0);
      check_val("t3_wait_gnt",    64'(m_gnt),    64'h2);
      check_val("t3_wait_hwdata", 64'(s_hwdata), 64'(WDATA1));
      check_val("t3_wait_haddr",  64'(s_haddr),  64'(ADDR1));
      step();
    end
    s_hready = 1'b1;
    #1;
    check_val("t3_done_hready", 64'(m_hready), 64'h2);
    check_val("t3_done_hresp",  64'(m_hresp),  64'h1);
    check_val("t3_done_hrdata", 64'(m_hrdata), 64'h1234_5678);
    check_val("t3_done_gnt",    64'(m_gnt),    64'h2);
    step();
    #1 check_val("t3_after_gnt", 64'(m_gnt), 64'h0);
    s_hready = 1'b0; s_hresp = 2'b00;

    // Timeout abort and saturation of the abort counter
    do_reset();
    step();
    m_req = 2'b01; s_hready = 1'b0; s_hrdata = 32'hCAFE_F00D;
    step();
    step();
    for (int i = 1; i < 16; i++) begin
      #1 check_val("t4_wait_hready", 64'(m_hready), 64'h0);
      step();
    end
    #1;
    check_val("t4_abort_hready", 64'(m_hready),    64'h1);
    check_val("t4_abort_hresp",  64'(m_hresp),     64'h1);
    check_val("t4_abort_hrdata", 64'(m_hrdata),    64'h0);
    check_val("t4_abort_cnt0",   64'(timeout_cnt), 64'h0);
    step();
    #1;
    check_val("t4_cnt1",      64'(timeout_cnt), 64'h1);
    check_val("t4_after_gnt", 64'(m_gnt),       64'h0);
    repeat (253 * 18) step();
    #1 check_val("t4_cnt254", 64'(timeout_cnt), 64'd254);
    repeat (18) step();
    #1 check_val("t4_cnt255", 64'(timeout_cnt), 64'd255);
    repeat (46 * 18) step();
    #1 check_val("t4_cnt_sat", 64'(timeout_cnt), 64'd255);

    // Reset asserted mid-DATA, then tie goes to master 0
    do_reset();
    step();
    m_req = 2'b11; s_hready = 1'b1;
    step();
    step();
    #1 check_val("t5_m0_hready", 64'(m_hready), 64'h1);
    step();
    step();
    #1 check_val("t5_m1_gnt", 64'(m_gnt), 64'h2);
    s_hready = 1'b0;
    step();
    #1 check_val("t5_data_gnt", 64'(m_gnt), 64'h2);
    rst_n = 1'b0; s_hready = 1'b1;
    #1;
    check_val("t5_rst_gnt",    64'(m_gnt),    64'h0);
    check_val("t5_rst_hready", 64'(m_hready), 64'h0);
    check_val("t5_rst_hsel",   64'(s_hsel),   64'h0);
    check_val("t5_rst_haddr",  64'(s_haddr),  64'h0);
    check_val("t5_rst_hwdata", 64'(s_hwdata), 64'h0);
    check_val("t5_rst_hresp",  64'(m_hresp),  64'h0);
    step();
    rst_n = 1'b1; m_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check_val("t5_no_stale_hready", 64'(m_hready), 64'h0);
    end
    m_req = 2'b11;
    #1 check_val("t5_idle_gnt", 64'(m_gnt), 64'h0);
    step();
    #1 check_val("t5_tie_gnt", 64'(m_gnt), 64'h1);
    m_req = 2'b00;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_2m.md
AHB_ARBITER_2M -- requirements
Module: ahb_arbiter_2m

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of masters and slave.
REQ-002 Parameter DATA_WIDTH, default 32, data width of masters and slave.
REQ-003 Parameter TIMEOUT, default 16, maximum DATA-state cycles with s_hready low before abort; legal range 2..255.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 m_req  input  2  per-master transfer request, bit i = master i.
REQ-007 m_haddr  input  2*ADDR_WIDTH  per-master address, master i in slice i.
REQ-008 m_hwdata  input  2*DATA_WIDTH  per-master write data.
REQ-009 m_hwrite / m_hsize / m_hburst  input  2 / 6 / 6  per-master direction, size (3 bits each), burst (3 bits each).
REQ-010 m_gnt  output  2  one-hot grant, at most one bit set.
REQ-011 m_hrdata  output  DATA_WIDTH  shared read data to masters.
REQ-012 m_hready  output  2  per-master transfer-complete strobe.
REQ-013 m_hresp  output  2  response to granted master, 00 OKAY, 01 ERROR.
REQ-014 s_hsel / s_haddr / s_hwdata / s_hwrite / s_hsize / s_hburst  output  1 / ADDR_WIDTH / DATA_WIDTH / 1 / 3 / 3  shared slave-side bus.
REQ-015 s_hrdata / s_hready / s_hresp  input  DATA_WIDTH / 1 / 2  slave response.
REQ-016 timeout_cnt  output  8  saturating count of aborted transfers.

Function
REQ-017 FSM states IDLE, ADDR, DATA; exactly one transfer in flight; no pipelining.
REQ-018 IDLE: if any m_req bit set, select winner, set m_gnt one-hot registered, go ADDR next cycle; no request -> stay IDLE.
REQ-019 Arbitration round-robin: both requesting -> master != last_served wins; one requesting -> that master wins.
REQ-020 last_served updates to winner when the transfer leaves DATA (complete or abort).
REQ-021 ADDR (exactly 1 cycle): s_hsel=1, s_haddr/s_hwrite/s_hsize/s_hburst = winner's slice; go DATA.
REQ-022 DATA: s_hsel=0, s_hwdata = winner's m_hwdata; address/control outputs hold ADDR values.
REQ-023 DATA with s_hready=1: m_hready[winner]=1 combinationally same cycle, m_hrdata=s_hrdata, m_hresp=s_hresp; next state IDLE, m_gnt cleared.
REQ-024 s_hresp value 1x (RETRY/SPLIT) is forwarded to master as 01 ERROR.
REQ-025 DATA wait counter counts cycles with s_hready=0; reaching TIMEOUT -> m_hready[winner]=1, m_hresp=01, m_hrdata=0, timeout_cnt += 1 (saturates at 255), next state IDLE.
REQ-026 m_gnt held until transfer ends regardless of m_req deassertion during ADDR/DATA.
REQ-027 New request cannot be granted in the cycle a transfer completes; earliest regrant is IDLE cycle after, giving minimum 3 cycles per transfer (IDLE, ADDR, DATA).
REQ-028 Non-granted master: m_hready bit 0 at all times; m_hrdata/m_hresp are 0 when no m_hready bit set.
REQ-029 m_hburst values other than 000 are passed through unchanged; arbiter treats every transfer as single.

Reset
REQ-030 rst_n low (any state, including mid-transfer): state IDLE, m_gnt=0, m_hready=0, m_hresp=00, m_hrdata=0, all s_* outputs 0, wait counter 0, timeout_cnt 0, last_served=1 (master 0 wins first tie).
REQ-031 Interrupted transfer is dropped; no m_hready issued for it after reset release.

Verification
REQ-032 Master 0 only, s_hready=1, s_hrdata=0xDEADBEEF -> m_gnt=01 cycle 1, s_hsel=1 with m_haddr slice 0 cycle 1, m_hready=01 and m_hrdata=0xDEADBEEF cycle 2.
REQ-033 Both request continuously out of reset, s_hready=1 -> grants alternate 01,10,01,10, one transfer every 3 cycles.
REQ-034 Master 1 granted, s_hready low 3 DATA cycles -> m_hready=10 on 4th DATA cycle, m_gnt stable throughout, s_hwdata = master 1 data.
REQ-035 s_hready held 0, TIMEOUT=16 -> m_hready pulse with m_hresp=01 after 16 DATA cycles, timeout_cnt 0->1; 300 aborts -> timeout_cnt=255.
REQ-036 rst_n asserted mid-DATA then released -> all outputs 0 immediately, no stale m_hready, next tie granted to master 0.
REQ-037 s_hresp=10 on completion -> m_hresp=01 to granted master.
